// File: rtl/seq_multiplier.sv
// Iterative shift-add 32x32 multiplier covering MUL/MULH/MULHSU/MULHU, one partial product per cycle.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends the iteration once the remaining multiplier bits are all zero.
module seq_multiplier (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic        r_neg;
  logic [31:0] r_result;

  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_accept;
  logic        w_last;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_product;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // a is signed for MULH and MULHSU, b only for MULH; MUL low half is sign-agnostic.
  assign w_a_neg   = ((op_i == 2'b01) || (op_i == 2'b10)) && a_i[31];
  assign w_b_neg   = (op_i == 2'b01) && b_i[31];
  assign w_accept  = (r_state == IDLE) && start_i;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_product = apply_sign(w_acc_nxt, r_neg);

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign w_last = (r_mplier[31:1] == 31'd0);
`else
  assign w_last = (r_cnt == 6'd31);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done_o      = 1'b0;
    stall_o     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = BUSY;
          stall_o     = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= 2'b00;
      r_mcand  <= 64'd0;
      r_acc    <= 64'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 6'd0;
      r_neg    <= 1'b0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_op     <= op_i;
      r_mcand  <= {32'd0, magnitude(a_i, w_a_neg)};
      r_mplier <= magnitude(b_i, w_b_neg);
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_neg    <= w_a_neg ^ w_b_neg;
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_cnt    <= r_cnt + 6'd1;
      // Result is taken from the final iteration's sum so it is valid the cycle DONE is entered.
      if (w_last) begin
        r_result <= (r_op == 2'b00) ? w_product[31:0] : w_product[63:32];
      end
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table plus scoreboard queue, with hand sequences
// for re-pulsed start, reset mid-operation and start held through DONE.
module tb_seq_multiplier;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        stall_o;

  int n_checks;
  int n_fail;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  seq_multiplier dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .result_o(result_o),
    .done_o  (done_o),
    .stall_o (stall_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference product built from wide signed arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycle index (start cycle = 0) at which done_o is expected.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic [31:0] m;
    int n;
    m = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic pop_check(input string name);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done_o with empty scoreboard, got 0x%08h", name, result_o);
    end else begin
      check(name, result_o, sb_q.pop_front());
    end
  endtask

  // One operation; rep_k re-pulses start with a=9 at that cycle, rst_k asserts reset at that cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int rep_k, input int rst_k);
    int lat;
    lat = exp_lat(op, b);
    sb_q.push_back(exp);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      end else if (k == 1) begin
        start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      end
      if (k == rep_k && rep_k > 0) begin
        start_i = 1'b1; a_i = 32'd9;
      end else if (k == rep_k + 1 && rep_k > 0) begin
        start_i = 1'b0;
      end
      if (k == rst_k) rst_ni = 1'b0;
      #1;
      if (rst_k >= 0 && k >= rst_k) begin
        check({name, " rst done"}, {31'd0, done_o}, 32'd0);
        check({name, " rst result"}, result_o, 32'd0);
        check({name, " rst stall"}, {31'd0, stall_o}, 32'd0);
        if (k == rst_k + 3) begin
          rst_ni = 1'b1;
          void'(sb_q.pop_front());
          return;
        end
      end else begin
        check($sformatf("%s done@%0d", name, k), {31'd0, done_o}, {31'd0, k == lat});
        check($sformatf("%s stall@%0d", name, k), {31'd0, stall_o}, {31'd0, k < lat});
        if (done_o) pop_check({name, " result"});
      end
    end
    @(negedge clk_i);
    #1;
    check({name, " hold"}, result_o, exp);
    check({name, " hold done"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    op_i     = 2'b00;
    a_i      = 32'd0;
    b_i      = 32'd0;

    vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000002A};
    vecs[1]  = '{2'b01, 32'h80000000,  32'h80000000,  32'h40000000};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF,  32'd3,         32'hFFFFFFFF};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF};
    vecs[4]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};
    vecs[5]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
    vecs[6]  = '{2'b00, 32'h12345678,  32'd1,         32'h12345678};
    vecs[7]  = '{2'b11, 32'd2,         32'h80000000,  32'h00000001};
    vecs[8]  = '{2'b00, 32'hDEADBEEF,  32'd0,         32'h00000000};
    vecs[9]  = '{2'b01, 32'hFFFFFFFE,  32'h7FFFFFFF,  32'hFFFFFFFF};
    for (int i = 10; i < 14; i++) begin
      vecs[i].op  = 2'(i - 10);
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].exp = ref_mul(vecs[i].op, vecs[i].a, vecs[i].b);
    end

    #12;
    check("reset result", result_o, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, -1, -1);
    end

    run_op("repulse", 2'b00, 32'd5, 32'd5, 32'd25, 10, -1);
    run_op("midrst", 2'b00, 32'd5, 32'd5, 32'd25, -1, 15);
    run_op("after rst", 2'b00, 32'd3, 32'd4, 32'd12, -1, -1);

    begin : held_start
      int lat;
      lat = exp_lat(2'b00, 32'd13);
      sb_q.push_back(32'd143);
      sb_q.push_back(32'd143);
      for (int k = 0; k <= 2 * lat + 1; k++) begin
        @(negedge clk_i);
        if (k == 0) begin
          start_i = 1'b1; op_i = 2'b00; a_i = 32'd11; b_i = 32'd13;
        end
        #1;
        check($sformatf("held done@%0d", k), {31'd0, done_o}, {31'd0, (k == lat) || (k == 2 * lat + 1)});
        if (done_o) pop_check("held result");
        if (k == 2 * lat + 1) start_i = 1'b0;
      end
      @(negedge clk_i);
      #1;
      check("held idle stall", {31'd0, stall_o}, 32'd0);
    end

    check("scoreboard empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one clock, `clk_i`; reset SHALL be `rst_ni`, asynchronous and active-low.
REQ-002 Port `clk_i`: input, 1 bit, rising-edge clock.
REQ-003 Port `rst_ni`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `start_i`: input, 1 bit; requests a multiply; sampled only in IDLE.
REQ-005 Port `op_i`: input, 2 bits; operation select:
- 00 = MUL, low 32 bits
- 01 = MULH, signed x signed, high 32 bits
- 10 = MULHSU, signed a x unsigned b, high 32 bits
- 11 = MULHU, unsigned x unsigned, high 32 bits
REQ-006 Port `a_i`: input, 32 bits; multiplicand (rs1).
REQ-007 Port `b_i`: input, 32 bits; multiplier (rs2).
REQ-008 Port `result_o`: output, 32 bits; selected half of the 64-bit product.
REQ-009 Port `done_o`: output, 1 bit; one-cycle pulse marking `result_o` valid.
REQ-010 Port `stall_o`: output, 1 bit; pipeline stall request.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE->BUSY on `start_i`=1.
- BUSY->DONE after the final iteration.
- DONE->IDLE unconditionally.
REQ-012 On accepting `start_i`, the block SHALL latch `op_i`, the magnitude of `a_i` and the magnitude of `b_i`, clear the 64-bit accumulator and the 6-bit counter, and record the product sign.
- Magnitude = two's-complement negation when the operand is negative and treated as signed per `op_i`.
- Product sign = XOR of operand signs treated as signed per `op_i`.
REQ-013 Each BUSY cycle SHALL perform one iteration and increment the counter:
- If multiplier LSB=1, add the shifted multiplicand to the 64-bit accumulator.
- Shift the 64-bit multiplicand left by 1.
- Shift the 32-bit multiplier right by 1.
REQ-014 Without early exit, BUSY SHALL last exactly 32 cycles; counting the start cycle as cycle 0, DONE is cycle 33.
REQ-015 On entering DONE, the block SHALL form the 64-bit product and register `result_o` from it.
- Product = accumulator, two's-complement negated if the recorded sign is negative.
- `result_o` = bits [31:0] for MUL, bits [63:32] otherwise.
REQ-016 `done_o` SHALL be 1 only in the DONE state.
REQ-017 `result_o` SHALL hold its value until the next DONE.
REQ-018 `stall_o` SHALL be 1 when state is BUSY, or when state is IDLE and `start_i`=1, combinationally.
- `stall_o` SHALL be 0 in DONE, so the pipeline advances and captures the result.
REQ-019 `start_i` asserted in BUSY or DONE SHALL be ignored; no queuing.
REQ-020 `start_i` held high through DONE SHALL start a new operation in the following IDLE cycle.
REQ-021 Operand changes after acceptance SHALL NOT affect the result.
REQ-022 The MULH product SHALL be exact for `a_i`=`b_i`=0x80000000: magnitudes of 2^31, product +2^62.

Reset
REQ-023 Reset assertion SHALL, asynchronously:
- force IDLE;
- zero `result_o`, the accumulator, the counter and the operand registers;
- drive `done_o`=0 and `stall_o`=0 (provided `start_i`=0).
REQ-024 Reset during BUSY SHALL abandon the operation, and no `done_o` SHALL follow.

Configuration
REQ-025 When macro `SEQ_MUL_EARLY_EXIT_EN` is defined, BUSY SHALL go to DONE after the first iteration that leaves the shifted multiplier register zero.
- Minimum 1 BUSY cycle; `b_i`=0 or 1 gives DONE in cycle 2.
- Result SHALL be identical to the full 32-iteration result.
REQ-026 When `SEQ_MUL_EARLY_EXIT_EN` is undefined, latency SHALL be fixed per REQ-014 for all operands.

Verification
REQ-027 MUL, a=7, b=6, macro off -> `done_o` in cycle 33 only, `result_o`=0x0000002A, `stall_o`=1 cycles 0-32.
REQ-028 MULH, a=b=0x80000000 -> `result_o`=0x40000000; MULH a=0xFFFFFFFF (-1), b=3 -> 0xFFFFFFFF.
REQ-029 MULHSU, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-030 MUL 5x5 with `start_i` re-pulsed at cycle 10 with a=9 -> single `done_o` at cycle 33, `result_o`=25.
REQ-031 `rst_ni` low at cycle 15 of a MUL -> `result_o`=0, no `done_o`.
- A following MUL 3x4 -> 12.
REQ-032 Macro on: MUL a=0x12345678, b=1 -> `done_o` in cycle 2, `result_o`=0x12345678.
- Macro on: b=0x80000000 (MULHU), a=2 -> `done_o` in cycle 33, `result_o`=0x00000001.
